// File: rtl/data_bus_ctrl_pkg.sv
// Shared constants for the CPU data-bus controller: access sizes, MMIO map,
// STATUS bit layout and control-bus bit positions.
package data_bus_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  localparam logic [63:0] OFF_TXDATA = 64'd0;
  localparam logic [63:0] OFF_STATUS = 64'd8;
  localparam logic [63:0] OFF_CYCLE  = 64'd16;

  localparam int unsigned ST_FULL    = 0;
  localparam int unsigned ST_EMPTY   = 1;
  localparam int unsigned ST_OVF     = 2;
  localparam int unsigned ST_CNT_LSB = 4;

  localparam int unsigned CTRL_WE = 2;
  localparam int unsigned CTRL_RE = 1;

  function automatic int unsigned size_bytes(input logic [1:0] sz);
    return 32'd1 << sz;
  endfunction

endpackage

// File: rtl/data_bus_ctrl_if.sv
// CPU memory bus plus console TX stream, grouped for the data-bus controller.
interface data_bus_ctrl_if;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [2:0]  ctrl;
  logic [1:0]  size;
  logic        load_unsigned;
  logic [63:0] rdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  modport master (
    output addr, wdata, ctrl, size, load_unsigned, tx_ready,
    input  rdata, tx_valid, tx_data
  );

  modport slave (
    input  addr, wdata, ctrl, size, load_unsigned, tx_ready,
    output rdata, tx_valid, tx_data
  );
endinterface

// File: rtl/dbus_tx_fifo.sv
// Byte FIFO for the console TX path; a push into a full FIFO only succeeds
// when a pop happens in the same cycle.
module dbus_tx_fifo #(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic [7:0]    i_data,
  input  logic          i_pop,
  output logic [7:0]    o_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [CW-1:0] r_cnt;
  logic          w_pop;
  logic          w_push;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_data  = r_mem[r_rd];

  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_push) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/data_bus_ctrl.sv
// Data-bus controller: little-endian byte RAM with sized loads/stores plus an
// MMIO console FIFO and STATUS. Define DBUS_CYCLE_CTR_EN for the cycle counter at +16.
module data_bus_ctrl
  import data_bus_ctrl_pkg::*;
#(
  parameter int unsigned MEM_BYTES  = 4096,
  parameter logic [63:0] MMIO_BASE  = 64'h0000_0000_FFFF_0000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  data_bus_ctrl_if.slave  bus
);

  localparam int unsigned AW = $clog2(MEM_BYTES);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    r_mem [MEM_BYTES];
  logic          r_ovf;
  logic          w_is_ram;
  logic [63:0]   w_off;
  logic          w_we;
  logic          w_re;
  logic [AW-1:0] w_base;
  int unsigned   w_nbytes;
  logic [63:0]   w_raw;
  logic [63:0]   w_ext;
  logic          w_sx;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [3:0]    w_cnt_sat;
  logic [63:0]   w_status;
  logic          w_st_wr;
  logic          w_unused_ok;

  assign w_is_ram    = (bus.addr < MMIO_BASE);
  assign w_off       = bus.addr - MMIO_BASE;
  assign w_we        = bus.ctrl[CTRL_WE];
  assign w_re        = bus.ctrl[CTRL_RE];
  assign w_base      = bus.addr[AW-1:0];
  assign w_nbytes    = size_bytes(bus.size);
  assign w_sx        = ~bus.load_unsigned;
  assign w_unused_ok = bus.ctrl[0];

  // Each byte lane wraps independently, so misaligned accesses at the top of RAM spill to 0.
  always_comb begin
    w_raw = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < w_nbytes) w_raw[8*i +: 8] = r_mem[w_base + AW'(i)];
    end
  end

  always_comb begin
    w_ext = w_raw;
    case (size_e'(bus.size))
      SZ_B:    w_ext = {{56{w_sx & w_raw[7]}},  w_raw[7:0]};
      SZ_H:    w_ext = {{48{w_sx & w_raw[15]}}, w_raw[15:0]};
      SZ_W:    w_ext = {{32{w_sx & w_raw[31]}}, w_raw[31:0]};
      default: w_ext = w_raw;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_we && w_is_ram) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (i < w_nbytes) r_mem[w_base + AW'(i)] <= bus.wdata[8*i +: 8];
      end
    end
  end

  assign w_push  = w_we & ~w_is_ram & (w_off == OFF_TXDATA);
  assign w_st_wr = w_we & ~w_is_ram & (w_off == OFF_STATUS);
  assign w_pop   = bus.tx_valid & bus.tx_ready;

  dbus_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_push  (w_push),
    .i_data  (bus.wdata[7:0]),
    .i_pop   (w_pop),
    .o_data  (bus.tx_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign bus.tx_valid = ~w_empty;

  always_ff @(posedge clk) begin
    if (!rst_n)                          r_ovf <= 1'b0;
    else if (w_st_wr)                    r_ovf <= 1'b0;
    else if (w_push & w_full & ~w_pop)   r_ovf <= 1'b1;
  end

  assign w_cnt_sat = (32'(w_count) > 32'd15) ? 4'hF : 4'(w_count);

  always_comb begin
    w_status                    = '0;
    w_status[ST_FULL]           = w_full;
    w_status[ST_EMPTY]          = w_empty;
    w_status[ST_OVF]            = r_ovf;
    w_status[ST_CNT_LSB +: 4]   = w_cnt_sat;
  end

`ifdef DBUS_CYCLE_CTR_EN
  logic [63:0] r_cycle;

  always_ff @(posedge clk) begin
    if (!rst_n)                                   r_cycle <= '0;
    else if (w_we && !w_is_ram && w_off == OFF_CYCLE) r_cycle <= bus.wdata;
    else                                          r_cycle <= r_cycle + 64'd1;
  end
`endif

  always_comb begin
    bus.rdata = '0;
    if (rst_n && w_re) begin
      if (w_is_ram)                   bus.rdata = w_ext;
      else if (w_off == OFF_STATUS)   bus.rdata = w_status;
`ifdef DBUS_CYCLE_CTR_EN
      else if (w_off == OFF_CYCLE)    bus.rdata = r_cycle;
`endif
    end
  end

endmodule

// File: tb/tb_data_bus_ctrl.sv
// Self-checking bench for data_bus_ctrl: queue/array reference model checked
// every cycle, directed literal checks, then randomized traffic with resets.
module tb_data_bus_ctrl;

  localparam int unsigned MEM   = 4096;
  localparam int unsigned DEPTH = 8;
  localparam logic [63:0] BASE  = 64'h0000_0000_FFFF_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_bus_ctrl_if bus ();

  data_bus_ctrl #(
    .MEM_BYTES  (MEM),
    .MMIO_BASE  (BASE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  byte unsigned mm [MEM];
  bit [7:0]     q [$];
  bit           ovf;
  bit [63:0]    cyc;
  bit           cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] model_rd();
    logic [63:0] v;
    logic [63:0] off;
    int unsigned n;
    v = '0;
    if (!rst_n || !bus.ctrl[1]) return 64'h0;
    if (bus.addr < BASE) begin
      n = 1 << bus.size;
      for (int i = 0; i < int'(n); i++) v[8*i +: 8] = mm[(bus.addr + 64'(i)) % MEM];
      if (!bus.load_unsigned && n < 8 && v[8*n-1]) v = v | (~64'h0 << (8*n));
      return v;
    end
    off = bus.addr - BASE;
    if (off == 64'd8)
      return {56'h0, (q.size() > 15 ? 4'hF : 4'(q.size())), 1'b0, ovf,
              q.size() == 0, q.size() == DEPTH};
`ifdef DBUS_CYCLE_CTR_EN
    if (off == 64'd16) return cyc;
`endif
    return 64'h0;
  endfunction

  // Reference model state advances on each rising edge from the bus inputs.
  always @(posedge clk) begin
    bit          pop;
    bit          full;
    bit          mmio;
    logic [63:0] off;
    if (!rst_n) begin
      q.delete();
      ovf = 1'b0;
      cyc = 64'h0;
    end else begin
      pop  = (q.size() != 0) && bus.tx_ready;
      full = (q.size() == DEPTH);
      mmio = (bus.addr >= BASE);
      off  = bus.addr - BASE;
      if (bus.ctrl[2] && !mmio)
        for (int i = 0; i < (1 << bus.size); i++)
          mm[(bus.addr + 64'(i)) % MEM] = bus.wdata[8*i +: 8];
      if (pop) void'(q.pop_front());
      if (bus.ctrl[2] && mmio && off == 64'd0) begin
        if (!full || pop) q.push_back(bus.wdata[7:0]);
        else              ovf = 1'b1;
      end
      if (bus.ctrl[2] && mmio && off == 64'd8) ovf = 1'b0;
      if (bus.ctrl[2] && mmio && off == 64'd16) cyc = bus.wdata;
      else                                      cyc = cyc + 64'd1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("rdata", bus.rdata, model_rd());
      chk("tx_valid", 64'(bus.tx_valid), 64'(q.size() != 0));
      if (q.size() != 0) chk("tx_data", 64'(bus.tx_data), 64'(q[0]));
    end
  end

  task automatic op(input bit we, input bit re, input logic [63:0] a,
                    input logic [63:0] d, input logic [1:0] sz, input bit uns);
    bus.ctrl          = {we, re, 1'b0};
    bus.addr          = a;
    bus.wdata         = d;
    bus.size          = sz;
    bus.load_unsigned = uns;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input string nm, input logic [63:0] exp);
    @(negedge clk);
    chk(nm, bus.rdata, exp);
    step();
  endtask

  initial begin
    logic [7:0] drain_exp [8];
    int unsigned sel;

    op(0, 1, BASE + 8, 0, 0, 0);
    bus.tx_ready = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_txv", 64'(bus.tx_valid), 64'h0);
    chk("rst_rdata_forced0", bus.rdata, 64'h0);
    rst_n = 1'b1;
    step();

    for (int a = 0; a < int'(MEM); a += 8) begin
      op(1, 0, 64'(a), {$urandom, $urandom}, 2'd3, 0);
      step();
    end

    op(1, 0, 64'h10, 64'h8877665544332211, 2'd3, 0); step();
    op(0, 1, 64'h17, 0, 2'd0, 0); look("ld_b_signed", 64'hFFFF_FFFF_FFFF_FF88);
    op(0, 1, 64'h17, 0, 2'd0, 1); look("ld_b_unsigned", 64'h88);
    op(0, 1, 64'h11, 0, 2'd1, 0); look("ld_h_signed", 64'h3322);

    op(1, 1, 64'h10, 64'h0, 2'd3, 1); look("rw_same_cycle", 64'h8877665544332211);
    op(0, 1, 64'h10, 0, 2'd3, 1); look("rw_after", 64'h0);

    op(1, 0, 64'(MEM - 2), 64'hAABBCCDD, 2'd2, 0); step();
    op(0, 1, 64'(MEM - 2), 0, 2'd2, 0); look("ld_w_wrap", 64'hFFFF_FFFF_AABB_CCDD);
    op(0, 1, 64'h0, 0, 2'd0, 1); look("wrap_byte0", 64'hBB);
    op(0, 1, 64'(MEM - 1), 0, 2'd0, 1); look("top_byte", 64'hCC);

    for (int k = 0; k < 3; k++) begin
      op(1, 0, BASE, 64'h41 + 64'(k), 2'd0, 0);
      step();
    end
    op(0, 1, BASE + 8, 0, 0, 0); look("status_abc", 64'h30);
    op(0, 1, BASE, 0, 0, 0); look("txdata_read0", 64'h0);
    op(0, 0, 0, 0, 0, 0);
    bus.tx_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("drain_abc", 64'(bus.tx_data), 64'h41 + 64'(k));
      step();
    end
    op(0, 1, BASE + 8, 0, 0, 0);
    @(negedge clk);
    chk("drain_done_txv", 64'(bus.tx_valid), 64'h0);
    chk("status_empty", bus.rdata, 64'h02);
    step();
    bus.tx_ready = 1'b0;

    for (int k = 0; k < 9; k++) begin
      op(1, 0, BASE, 64'h60 + 64'(k), 2'd0, 0);
      step();
    end
    op(0, 1, BASE + 8, 0, 0, 0); look("status_ovf", 64'h85);
    op(1, 0, BASE + 8, 64'hDEAD, 0, 0); step();
    op(0, 1, BASE + 8, 0, 0, 0); look("status_ovf_clr", 64'h81);

    op(1, 0, BASE, 64'h99, 2'd0, 0);
    bus.tx_ready = 1'b1;
    step();
    bus.tx_ready = 1'b0;
    op(0, 1, BASE + 8, 0, 0, 0); look("status_full_pp", 64'h81);
    for (int k = 0; k < 7; k++) drain_exp[k] = 8'h61 + 8'(k);
    drain_exp[7] = 8'h99;
    op(0, 0, 0, 0, 0, 0);
    bus.tx_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("drain_full_order", 64'(bus.tx_data), 64'(drain_exp[k]));
      step();
    end
    bus.tx_ready = 1'b0;

    for (int k = 0; k < 3; k++) begin
      op(1, 0, BASE, 64'h70 + 64'(k), 2'd0, 0);
      step();
    end
    op(1, 0, 64'h200, 64'h5A, 2'd0, 0); step();
    rst_n = 1'b0;
    op(1, 0, 64'h200, 64'hEE, 2'd0, 0); step();
    rst_n = 1'b0;
    op(1, 0, BASE, 64'h77, 2'd0, 0); step();
    rst_n = 1'b1;
`ifdef DBUS_CYCLE_CTR_EN
    op(0, 1, BASE + 16, 0, 0, 0); look("cyc_after_reset", 64'h0);
    op(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) step();
    op(0, 1, BASE + 16, 0, 0, 0); look("cyc_5", 64'h5);
    op(1, 0, BASE + 16, 64'd1000, 0, 0); step();
    op(0, 1, BASE + 16, 0, 0, 0); look("cyc_load", 64'd1000);
`else
    op(1, 0, BASE + 16, 64'd1000, 0, 0); step();
    op(0, 1, BASE + 16, 0, 0, 0); look("cyc_unmapped", 64'h0);
`endif
    op(0, 1, BASE + 8, 0, 0, 0);
    @(negedge clk);
    chk("reset_txv", 64'(bus.tx_valid), 64'h0);
    chk("reset_status", bus.rdata, 64'h02);
    step();
    op(0, 1, 64'h200, 0, 2'd0, 1); look("ram_kept", 64'h5A);

    for (int n = 0; n < 3000; n++) begin
      rst_n        = ($urandom_range(0, 199) != 0);
      bus.tx_ready = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3, 4: bus.addr = 64'($urandom_range(0, MEM - 1));
        5:             bus.addr = BASE - 64'($urandom_range(1, 8));
        6:             bus.addr = 64'h1234_0000 + 64'($urandom_range(0, MEM - 1));
        7:             bus.addr = BASE;
        8:             bus.addr = BASE + 64'd8;
        default:       bus.addr = BASE + 64'($urandom_range(1, 4) * 4);
      endcase
      bus.ctrl          = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
      bus.wdata         = {$urandom, $urandom};
      bus.size          = 2'($urandom_range(0, 3));
      bus.load_unsigned = 1'($urandom_range(0, 1));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
